l1_d_cache_ctrl_nway: RTL and testbench

//  Parametrised N-way set-associative write-back / write-allocate L1 data cache controller.

---
 rtl/l1_d_cache_ctrl_nway_if.sv | 52 +++++
 rtl/l1_d_cache_ctrl_nway.sv | 227 ++++++++++++++++++++++
 tb/tb_l1_d_cache_ctrl_nway.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/l1_d_cache_ctrl_nway_if.sv
// rtl/l1_d_cache_ctrl_nway_if.sv - core/L2 handshake bundle for the N-way L1 D cache controller (L1D_PERF_CNT_EN adds counters)
interface l1_d_cache_ctrl_nway_if #(
  parameter int TAG_W   = 20,
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2
);
  localparam int WS_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] index;
  logic               read_C_L1;
  logic               write_C_L1;
  logic               flush;
  logic               ready_L2_L1;
  logic               write_L1_L2_done;
  logic               stall;
  logic               refill;
  logic               update;
  logic               read_L1_L2;
  logic               write_L1_L2;
  logic [WS_W-1:0]    way_sel;
  logic [TAG_W-1:0]   wb_tag;
  logic [INDEX_W-1:0] wb_index;
  logic               flush_done;
`ifdef L1D_PERF_CNT_EN
  logic [31:0]        hit_cnt;
  logic [31:0]        miss_cnt;
  logic [31:0]        wb_cnt;

  modport master (
    output tag, index, read_C_L1, write_C_L1, flush, ready_L2_L1, write_L1_L2_done,
    input  stall, refill, update, read_L1_L2, write_L1_L2, way_sel, wb_tag, wb_index,
           flush_done, hit_cnt, miss_cnt, wb_cnt
  );
  modport slave (
    input  tag, index, read_C_L1, write_C_L1, flush, ready_L2_L1, write_L1_L2_done,
    output stall, refill, update, read_L1_L2, write_L1_L2, way_sel, wb_tag, wb_index,
           flush_done, hit_cnt, miss_cnt, wb_cnt
  );
`else
  modport master (
    output tag, index, read_C_L1, write_C_L1, flush, ready_L2_L1, write_L1_L2_done,
    input  stall, refill, update, read_L1_L2, write_L1_L2, way_sel, wb_tag, wb_index,
           flush_done
  );
  modport slave (
    input  tag, index, read_C_L1, write_C_L1, flush, ready_L2_L1, write_L1_L2_done,
    output stall, refill, update, read_L1_L2, write_L1_L2, way_sel, wb_tag, wb_index,
           flush_done
  );
`endif
endinterface

// File: rtl/l1_d_cache_ctrl_nway.sv
// rtl/l1_d_cache_ctrl_nway.sv - N-way write-back L1 D cache controller with tree PLRU and flush walk (L1D_PERF_CNT_EN adds counters)
module l1_d_cache_ctrl_nway #(
  parameter int TAG_W   = 20,
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2
) (
  input logic               clk,
  input logic               rst,
  l1_d_cache_ctrl_nway_if.slave bus
);
  localparam int SETS = 1 << INDEX_W;
  localparam int WS_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LVL  = (WAYS > 1) ? $clog2(WAYS) : 0;
  localparam int PL_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam logic [WS_W-1:0]    LAST_WAY = WS_W'(WAYS - 1);
  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(SETS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITEBACK = 3'd1;
  localparam logic [2:0] ALLOCATE  = 3'd2;
  localparam logic [2:0] REFILL    = 3'd3;
  localparam logic [2:0] FL_SCAN   = 3'd4;
  localparam logic [2:0] FL_WB     = 3'd5;
  localparam logic [2:0] FL_DONE   = 3'd6;

  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [PL_W-1:0]    plru_q  [SETS];
  logic [2:0]         state_q;
  logic [WS_W-1:0]    vic_q;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_idx_q;
  logic [INDEX_W-1:0] fl_set_q;
  logic [WS_W-1:0]    fl_way_q;

  logic               req, wr, any_hit, fl_last;
  logic [WAYS-1:0]    hit_vec;
  logic [WS_W-1:0]    hit_way, inv_way, victim, fl_way_nx;
  logic [INDEX_W-1:0] fl_set_nx;

  // PLRU tree: node n (1-based heap) bit 0 steers the victim left (child 2n), 1 right (2n+1)
  function automatic logic [WS_W-1:0] plru_victim(input logic [PL_W-1:0] p);
    int node;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      int nxt;
      nxt = node * 2;
      for (int n = 1; n < WAYS; n++)
        if (n == node && p[n-1]) nxt = node * 2 + 1;
      node = nxt;
    end
    return WS_W'(node - WAYS);
  endfunction

  // Point every node on the path to way w away from it
  function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] p, input logic [WS_W-1:0] w);
    int leaf;
    leaf = WAYS + int'(w);
    for (int l = 0; l < LVL; l++)
      for (int n = 1; n < WAYS; n++)
        if (n == ((leaf >> l) >> 1)) p[n-1] = (((leaf >> l) & 1) == 0);
    return p;
  endfunction

  // Tag compare, hit way, and victim choice for the presented request
  always_comb begin
    req     = bus.read_C_L1 | bus.write_C_L1;
    wr      = bus.write_C_L1;
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[bus.index][w] && (tag_q[bus.index][w] == bus.tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WS_W'(w);
      if (!valid_q[bus.index][w]) inv_way = WS_W'(w);
    end
    any_hit   = |hit_vec;
    victim    = (&valid_q[bus.index]) ? plru_victim(plru_q[bus.index]) : inv_way;
    fl_last   = (fl_set_q == LAST_SET) && (fl_way_q == LAST_WAY);
    fl_way_nx = (fl_way_q == LAST_WAY) ? '0 : fl_way_q + 1'b1;
    fl_set_nx = (fl_way_q == LAST_WAY) ? fl_set_q + 1'b1 : fl_set_q;
  end

  // Controller state, line metadata and flush walk position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vic_q     <= '0;
      req_tag_q <= '0;
      req_idx_q <= '0;
      fl_set_q  <= '0;
      fl_way_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            state_q  <= FL_SCAN;
            fl_set_q <= '0;
            fl_way_q <= '0;
          end else if (req && any_hit) begin
            plru_q[bus.index] <= plru_touch(plru_q[bus.index], hit_way);
            if (wr) dirty_q[bus.index][hit_way] <= 1'b1;
          end else if (req) begin
            vic_q     <= victim;
            req_tag_q <= bus.tag;
            req_idx_q <= bus.index;
            state_q   <= (valid_q[bus.index][victim] && dirty_q[bus.index][victim]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (bus.write_L1_L2_done) state_q <= ALLOCATE;
        ALLOCATE:  if (bus.ready_L2_L1) state_q <= REFILL;
        REFILL: begin
          valid_q[req_idx_q][vic_q] <= 1'b1;
          dirty_q[req_idx_q][vic_q] <= 1'b0;
          plru_q[req_idx_q]         <= plru_touch(plru_q[req_idx_q], vic_q);
          state_q                   <= IDLE;
        end
        FL_SCAN: begin
          plru_q[fl_set_q] <= '0;
          if (dirty_q[fl_set_q][fl_way_q]) begin
            state_q <= FL_WB;
          end else begin
            valid_q[fl_set_q][fl_way_q] <= 1'b0;
            fl_set_q <= fl_set_nx;
            fl_way_q <= fl_way_nx;
            state_q  <= fl_last ? FL_DONE : FL_SCAN;
          end
        end
        FL_WB: if (bus.write_L1_L2_done) begin
          valid_q[fl_set_q][fl_way_q] <= 1'b0;
          dirty_q[fl_set_q][fl_way_q] <= 1'b0;
          fl_set_q <= fl_set_nx;
          fl_way_q <= fl_way_nx;
          state_q  <= fl_last ? FL_DONE : FL_SCAN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag array write on line fill; validity is tracked separately, so no reset needed
  always_ff @(posedge clk) begin
    if (state_q == REFILL) tag_q[req_idx_q][vic_q] <= req_tag_q;
  end

  // Core stall, data-array steering and L2 handshake outputs
  always_comb begin
    bus.stall       = 1'b0;
    bus.refill      = 1'b0;
    bus.update      = 1'b0;
    bus.read_L1_L2  = 1'b0;
    bus.write_L1_L2 = 1'b0;
    bus.way_sel     = '0;
    bus.wb_tag      = '0;
    bus.wb_index    = '0;
    bus.flush_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          bus.stall = 1'b1;
        end else if (req && any_hit) begin
          bus.way_sel = hit_way;
          bus.update  = wr;
        end else if (req) begin
          bus.stall   = 1'b1;
          bus.way_sel = victim;
        end
      end
      WRITEBACK: begin
        bus.stall       = 1'b1;
        bus.write_L1_L2 = 1'b1;
        bus.way_sel     = vic_q;
        bus.wb_tag      = tag_q[req_idx_q][vic_q];
        bus.wb_index    = req_idx_q;
      end
      ALLOCATE: begin
        bus.stall      = 1'b1;
        bus.read_L1_L2 = 1'b1;
        bus.way_sel    = vic_q;
      end
      REFILL: begin
        bus.stall   = 1'b1;
        bus.refill  = 1'b1;
        bus.way_sel = vic_q;
      end
      FL_SCAN: begin
        bus.stall   = 1'b1;
        bus.way_sel = fl_way_q;
      end
      FL_WB: begin
        bus.stall       = 1'b1;
        bus.write_L1_L2 = 1'b1;
        bus.way_sel     = fl_way_q;
        bus.wb_tag      = tag_q[fl_set_q][fl_way_q];
        bus.wb_index    = fl_set_q;
      end
      FL_DONE: bus.flush_done = 1'b1;
      default: bus.stall = 1'b0;
    endcase
  end

`ifdef L1D_PERF_CNT_EN
  logic hit_ev, miss_ev, wb_ev;
  assign hit_ev  = (state_q == IDLE) && !bus.flush && req && any_hit;
  assign miss_ev = (state_q == IDLE) && !bus.flush && req && !any_hit;
  assign wb_ev   = bus.write_L1_L2_done && ((state_q == WRITEBACK) || (state_q == FL_WB));

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hit_cnt  <= '0;
      bus.miss_cnt <= '0;
      bus.wb_cnt   <= '0;
    end else begin
      if (hit_ev && bus.hit_cnt != 32'hFFFF_FFFF)   bus.hit_cnt  <= bus.hit_cnt + 32'd1;
      if (miss_ev && bus.miss_cnt != 32'hFFFF_FFFF) bus.miss_cnt <= bus.miss_cnt + 32'd1;
      if (wb_ev && bus.wb_cnt != 32'hFFFF_FFFF)     bus.wb_cnt   <= bus.wb_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l1_d_cache_ctrl_nway.sv
// tb/tb_l1_d_cache_ctrl_nway.sv - self-checking bench for l1_d_cache_ctrl_nway (2-way, 64 sets)
module tb_l1_d_cache_ctrl_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  l1_d_cache_ctrl_nway_if #(.TAG_W(20), .INDEX_W(6), .WAYS(2)) bus ();
  l1_d_cache_ctrl_nway #(.TAG_W(20), .INDEX_W(6), .WAYS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          wr;
    logic [19:0] tg;
    logic [5:0]  ix;
    bit          e_hit;
    bit          e_way;
    bit          e_wb;
  } vec_t;

  // Reference: per-set line contents plus the way that would be evicted next
  logic [19:0] m_tag [64][2];
  bit          m_v   [64][2];
  bit          m_d   [64][2];
  bit          m_lru [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < 64; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0; m_d[s][w] = 1'b0; m_tag[s][w] = '0;
      end
    end
  endfunction

  // One load/store from IDLE to completion; called and returns just after a rising edge
  task automatic do_access(input bit wr, input logic [19:0] tg, input logic [5:0] ix,
                           output bit o_hit, output bit o_way, output bit o_wb);
    bit mh; int mw; int v; int n;
    o_wb = 1'b0; o_way = 1'b0; mh = 1'b0; mw = 0;
    bus.write_C_L1 = wr;
    bus.read_C_L1  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.tag = tg; bus.index = ix;
    for (int w = 0; w < 2; w++) if (m_v[ix][w] && m_tag[ix][w] == tg) begin mh = 1'b1; mw = w; end
    @(negedge clk);
    o_hit = !bus.stall;
    if (mh) begin
      chk("hit_stall", bus.stall, 0);
      chk("hit_way", bus.way_sel, mw);
      chk("hit_update", bus.update, wr);
      o_way = bus.way_sel;
      m_lru[ix] = (mw == 0);
      if (wr) m_d[ix][mw] = 1'b1;
    end else begin
      v = !m_v[ix][0] ? 0 : (!m_v[ix][1] ? 1 : int'(m_lru[ix]));
      chk("miss_stall", bus.stall, 1);
      chk("miss_update", bus.update, 0);
      @(posedge clk); #1;
      if (m_v[ix][v] && m_d[ix][v]) begin
        @(negedge clk);
        chk("wb_req", bus.write_L1_L2, 1);
        chk("wb_noread", bus.read_L1_L2, 0);
        chk("wb_tag", bus.wb_tag, m_tag[ix][v]);
        chk("wb_index", bus.wb_index, ix);
        o_wb = 1'b1;
        n = $urandom_range(0, 2);
        bus.ready_L2_L1 = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
          @(posedge clk); #1; bus.ready_L2_L1 = 1'b0;
          @(negedge clk); chk("wb_hold", bus.write_L1_L2, 1);
        end
        bus.write_L1_L2_done = 1'b1;
        @(posedge clk); #1; bus.write_L1_L2_done = 1'b0; bus.ready_L2_L1 = 1'b0;
      end
      @(negedge clk);
      chk("alloc_req", bus.read_L1_L2, 1);
      chk("alloc_nowb", bus.write_L1_L2, 0);
      n = $urandom_range(0, 2);
      bus.write_L1_L2_done = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1; bus.write_L1_L2_done = 1'b0;
        @(negedge clk); chk("alloc_hold", bus.read_L1_L2, 1);
      end
      bus.ready_L2_L1 = 1'b1;
      @(posedge clk); #1; bus.ready_L2_L1 = 1'b0; bus.write_L1_L2_done = 1'b0;
      @(negedge clk);
      chk("refill", bus.refill, 1);
      chk("refill_way", bus.way_sel, v);
      chk("refill_stall", bus.stall, 1);
      m_tag[ix][v] = tg; m_v[ix][v] = 1'b1; m_d[ix][v] = 1'b0; m_lru[ix] = (v == 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_hit_stall", bus.stall, 0);
      chk("post_hit_way", bus.way_sel, v);
      chk("post_hit_update", bus.update, wr);
      o_way = bus.way_sel;
      if (wr) m_d[ix][v] = 1'b1;
    end
    @(posedge clk); #1;
    bus.read_C_L1 = 1'b0; bus.write_C_L1 = 1'b0;
  endtask

  // Full flush walk; every writeback is accepted on its second cycle
  task automatic do_flush(output int nwb);
    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];
    int d, cyc, done_cyc, stall_bad, wcnt;
    bit seen;
    cyc = 0; done_cyc = -1; stall_bad = 0; wcnt = 0; seen = 1'b0;
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 2; w++)
        if (m_d[s][w]) exp_q.push_back({m_tag[s][w], 6'(s)});
    d = exp_q.size();
    bus.flush = 1'b1;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      if (bus.flush_done) begin
        seen = 1'b1; done_cyc = cyc;
        chk("flush_done_stall", bus.stall, 0);
        bus.flush = 1'b0;
      end else begin
        if (!bus.stall) stall_bad++;
        if (bus.write_L1_L2) begin
          wcnt++;
          if (wcnt == 2) begin
            got_q.push_back({bus.wb_tag, bus.wb_index});
            bus.write_L1_L2_done = 1'b1;
            wcnt = 0;
          end
        end
      end
      @(posedge clk); #1; bus.write_L1_L2_done = 1'b0; cyc++;
    end
    bus.flush = 1'b0;
    chk("flush_done_seen", seen, 1);
    chk("flush_cycles", done_cyc, 1 + 128 + 2 * d);
    chk("flush_stall_low", stall_bad, 0);
    chk("flush_wb_count", got_q.size(), d);
    for (int i = 0; i < d && i < got_q.size(); i++) chk("flush_wb_line", got_q[i], exp_q[i]);
    nwb = got_q.size();
    m_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    bit h, w, wb;
    int nwb;
    logic [19:0] tpool[4];
    logic [5:0]  ipool[4];

    vecs[0]  = '{0, 20'h12345, 6'd3,  0, 0, 0};
    vecs[1]  = '{0, 20'h12345, 6'd3,  1, 0, 0};
    vecs[2]  = '{1, 20'h12345, 6'd3,  1, 0, 0};
    vecs[3]  = '{0, 20'h00AAA, 6'd5,  0, 0, 0};
    vecs[4]  = '{0, 20'h00BBB, 6'd5,  0, 1, 0};
    vecs[5]  = '{0, 20'h00AAA, 6'd5,  1, 0, 0};
    vecs[6]  = '{0, 20'h00CCC, 6'd5,  0, 1, 0};
    vecs[7]  = '{1, 20'h00CCC, 6'd5,  1, 1, 0};
    vecs[8]  = '{0, 20'h00AAA, 6'd5,  1, 0, 0};
    vecs[9]  = '{0, 20'h00DDD, 6'd5,  0, 1, 1};
    vecs[10] = '{0, 20'h00EEE, 6'd3,  0, 1, 0};
    vecs[11] = '{0, 20'h00FFF, 6'd3,  0, 0, 1};
    vecs[12] = '{1, 20'h00FFF, 6'd3,  1, 0, 0};
    vecs[13] = '{1, 20'h00AAA, 6'd5,  1, 0, 0};
    vecs[14] = '{1, 20'h00111, 6'd60, 0, 0, 0};
    tpool = '{20'h12345, 20'h00AAA, 20'h00BBB, 20'h00CCC};
    ipool = '{6'd3, 6'd5, 6'd7, 6'd60};

    bus.tag = '0; bus.index = '0; bus.read_C_L1 = 1'b0; bus.write_C_L1 = 1'b0;
    bus.flush = 1'b0; bus.ready_L2_L1 = 1'b0; bus.write_L1_L2_done = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", {bus.stall, bus.refill, bus.update, bus.read_L1_L2, bus.write_L1_L2,
                      bus.way_sel, bus.flush_done}, 0);
    chk("reset_wb", {bus.wb_tag, bus.wb_index}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      do_access(vecs[i].wr, vecs[i].tg, vecs[i].ix, h, w, wb);
      chk($sformatf("vec%0d_hit", i), h, vecs[i].e_hit);
      chk($sformatf("vec%0d_way", i), w, vecs[i].e_way);
      chk($sformatf("vec%0d_wb", i), wb, vecs[i].e_wb);
    end

    do_flush(nwb);
    chk("flush3_wbs", nwb, 3);
    do_access(0, 20'h00FFF, 6'd3, h, w, wb);
    chk("after_flush_miss", h, 0);

    for (int i = 0; i < 150; i++)
      do_access(1'($urandom_range(0, 1)), tpool[$urandom_range(0, 3)],
                ipool[$urandom_range(0, 3)], h, w, wb);
    do_flush(nwb);

    do_access(0, 20'h00AAA, 6'd5, h, w, wb);
    bus.read_C_L1 = 1'b1; bus.tag = 20'h00777; bus.index = 6'd5;
    @(negedge clk); chk("rst_miss_stall", bus.stall, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rst_alloc_req", bus.read_L1_L2, 1);
    #1 rst = 1'b1; bus.read_C_L1 = 1'b0;
    #1;
    chk("rst_read_drop", bus.read_L1_L2, 0);
    chk("rst_stall_drop", bus.stall, 0);
    @(negedge clk); rst = 1'b0; m_reset();
    @(posedge clk); #1;
    do_access(0, 20'h00AAA, 6'd5, h, w, wb);
    chk("rst_line_lost", h, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
